// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Register-file geometry shared by the scoreboard slice.
// Revision    : 1.0
// ============================================================================
package regfile_pkg;

   localparam int NREGS = 32;
   localparam int AW    = 5;

   typedef logic [AW-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard_if
// Description : Decode issue and writeback signals seen by the scoreboard.
// Revision    : 1.0
// ============================================================================
interface regfile_scoreboard_if;
   import regfile_pkg::*;

   logic     issue_valid;
   reg_idx_t issue_rs1;
   reg_idx_t issue_rs2;
   logic     issue_use_rs1;
   logic     issue_use_rs2;
   reg_idx_t issue_rd;
   logic     issue_rd_we;
   logic     issue_ready;
   logic     stall;
   logic     wb_valid;
   reg_idx_t wb_rd;

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
      output issue_rd, issue_rd_we, wb_valid, wb_rd,
      input  issue_ready, stall
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
      input  issue_rd, issue_rd_we, wb_valid, wb_rd,
      output issue_ready, stall
   );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : Saturating up/down pending-write counter with synchronous clear.
// Revision    : 1.0
// ============================================================================
module sb_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   // Coincident inc and dec cancel, so the count is left untouched.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_count <= '0;
      end else if (inc && !dec && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end else if (dec && !inc && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Pending-write scoreboard gating decode issue on RAW/WAW limits.
//               Optional same-cycle writeback bypass: REGFILE_SB_WB_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int CNTW  = 2,
   parameter int STATW = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_scoreboard_if.slave  sb,
   input  logic                 flush,
   output logic [NREGS-1:0]     busy_vec,
   output logic                 wb_underflow,
   output logic [STATW-1:0]     stall_cycles
);

   localparam logic [CNTW-1:0] c_cnt_max = '1;
   localparam logic [CNTW-1:0] c_cnt_one = CNTW'(1);

   logic [CNTW-1:0]  w_cnt [NREGS];
   logic [NREGS-1:1] w_inc;
   logic [NREGS-1:1] w_dec;
   logic             w_haz1;
   logic             w_haz2;
   logic             w_rd_full;
   logic             w_ready;
   logic             w_stall;
   logic             w_fire_we;
   logic             w_wb_fire;
   logic             r_wb_underflow;
   logic [STATW-1:0] r_stall_cycles;

   assign w_cnt[0] = '0;

   always_comb begin
      w_haz1 = sb.issue_use_rs1 && (sb.issue_rs1 != REG_ZERO) && (w_cnt[sb.issue_rs1] != '0);
      w_haz2 = sb.issue_use_rs2 && (sb.issue_rs2 != REG_ZERO) && (w_cnt[sb.issue_rs2] != '0);
`ifdef REGFILE_SB_WB_BYPASS_EN
      // Last outstanding write lands on the falling edge, in time for the read.
      if (sb.wb_valid && (sb.wb_rd == sb.issue_rs1) && (w_cnt[sb.issue_rs1] == c_cnt_one))
         w_haz1 = 1'b0;
      if (sb.wb_valid && (sb.wb_rd == sb.issue_rs2) && (w_cnt[sb.issue_rs2] == c_cnt_one))
         w_haz2 = 1'b0;
`endif
   end

   assign w_rd_full = sb.issue_rd_we && (sb.issue_rd != REG_ZERO) && (w_cnt[sb.issue_rd] == c_cnt_max);
   assign w_ready   = !w_haz1 && !w_haz2 && !w_rd_full;
   assign w_stall   = sb.issue_valid && !w_ready;
   assign w_fire_we = sb.issue_valid && w_ready && sb.issue_rd_we;
   assign w_wb_fire = sb.wb_valid && (sb.wb_rd != REG_ZERO);

   assign sb.issue_ready = w_ready;
   assign sb.stall       = w_stall;

   generate
      for (genvar i = 1; i < NREGS; i++) begin : g_cnt
         assign w_inc[i] = w_fire_we   && (sb.issue_rd == reg_idx_t'(i));
         assign w_dec[i] = sb.wb_valid && (sb.wb_rd    == reg_idx_t'(i));

         sb_counter #(
            .W     (CNTW)
         ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (flush),
            .inc   (w_inc[i]),
            .dec   (w_dec[i]),
            .count (w_cnt[i])
         );
      end
   endgenerate

   always_comb begin
      busy_vec = '0;
      for (int i = 0; i < NREGS; i++) begin
         busy_vec[i] = (w_cnt[i] != '0);
      end
   end

   // A writeback swallowed by a flush is discarded, so it cannot underflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wb_underflow <= 1'b0;
      end else if (w_wb_fire && !flush && (w_cnt[sb.wb_rd] == '0)) begin
         r_wb_underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= '0;
      end else if (w_stall && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   assign wb_underflow = r_wb_underflow;
   assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Scoreboard bench: directed scenarios plus random issue/writeback.
// Revision    : 1.0
// ============================================================================
module tb_regfile_scoreboard;
   import regfile_pkg::*;

   localparam int CNTW     = 2;
   localparam int STATW    = 16;
   localparam int MAXC     = (1 << CNTW) - 1;
   localparam int STAT_MAX = (1 << STATW) - 1;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   logic [NREGS-1:0] busy_vec;
   logic             wb_underflow;
   logic [STATW-1:0] stall_cycles;

   always #5 clk = ~clk;

   regfile_scoreboard_if sb_if ();

   regfile_scoreboard #(
      .CNTW         (CNTW),
      .STATW        (STATW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sb           (sb_if),
      .flush        (flush),
      .busy_vec     (busy_vec),
      .wb_underflow (wb_underflow),
      .stall_cycles (stall_cycles)
   );

   typedef struct {
      bit               ready;
      bit               stall;
      logic [NREGS-1:0] busy;
      bit               uf;
      int               stat;
   } exp_t;

   exp_t q[$];

   // Reference state: pending writes per register, sticky flag, stall count.
   int m_cnt [NREGS];
   bit m_uf;
   int m_stat;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit src_hazard(input bit use_src, input int idx, input bit wv, input int wrd);
      bit bypass = 1'b0;
`ifdef REGFILE_SB_WB_BYPASS_EN
      bypass = 1'b1;
`endif
      if (!use_src || idx == 0 || m_cnt[idx] == 0) return 1'b0;
      if (bypass && wv && wrd == idx && m_cnt[idx] == 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic cyc(input bit rst, input bit fl, input bit iv,
                      input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit we, input bit wv, input int wrd);
      exp_t e;
      bit   rdy;
      bit   stl;
      bit   inc_ok;
      bit   wb_ok;
      @(posedge clk);
      #1;
      reset                = rst;
      flush                = fl;
      sb_if.issue_valid    = iv;
      sb_if.issue_rs1      = rs1[AW-1:0];
      sb_if.issue_use_rs1  = u1;
      sb_if.issue_rs2      = rs2[AW-1:0];
      sb_if.issue_use_rs2  = u2;
      sb_if.issue_rd       = rd[AW-1:0];
      sb_if.issue_rd_we    = we;
      sb_if.wb_valid       = wv;
      sb_if.wb_rd          = wrd[AW-1:0];

      rdy = !src_hazard(u1, rs1, wv, wrd) && !src_hazard(u2, rs2, wv, wrd)
            && !(we && rd != 0 && m_cnt[rd] == MAXC);
      stl = iv && !rdy;
      e.ready = rdy;
      e.stall = stl;
      e.busy  = '0;
      for (int i = 0; i < NREGS; i++) e.busy[i] = (m_cnt[i] != 0);
      e.uf    = m_uf;
      e.stat  = m_stat;
      q.push_back(e);

      if (rst) begin
         for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
         m_uf   = 1'b0;
         m_stat = 0;
      end else begin
         if (stl && m_stat < STAT_MAX) m_stat++;
         if (fl) begin
            for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
         end else begin
            inc_ok = iv && rdy && we && rd != 0;
            wb_ok  = wv && wrd != 0;
            if (wb_ok && m_cnt[wrd] == 0) m_uf = 1'b1;
            if (!(inc_ok && wb_ok && rd == wrd)) begin
               if (inc_ok) m_cnt[rd]++;
               if (wb_ok && m_cnt[wrd] > 0) m_cnt[wrd]--;
            end
         end
      end
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rand_cycle();
      int pend[$];
      bit rst;
      bit fl;
      bit wv;
      int wrd;
      rst = ($urandom_range(0, 299) == 0);
      fl  = ($urandom_range(0, 39) == 0);
      wv  = !fl && ($urandom_range(0, 2) != 0);
      for (int i = 1; i < NREGS; i++) if (m_cnt[i] != 0) pend.push_back(i);
      if (pend.size() > 0 && $urandom_range(0, 9) < 8)
         wrd = pend[$urandom_range(0, pend.size() - 1)];
      else
         wrd = $urandom_range(0, 12);
      cyc(rst, fl, ($urandom_range(0, 4) != 0),
          $urandom_range(0, 12), $urandom_range(0, 1),
          $urandom_range(0, 12), $urandom_range(0, 1),
          $urandom_range(0, 12), $urandom_range(0, 1),
          wv, wrd);
   endtask

   // Monitor: one expected response per cycle, compared away from the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("issue_ready",  64'(sb_if.issue_ready), 64'(e.ready));
            chk("stall",        64'(sb_if.stall),       64'(e.stall));
            chk("busy_vec",     64'(busy_vec),          64'(e.busy));
            chk("wb_underflow", 64'(wb_underflow),      64'(e.uf));
            chk("stall_cycles", 64'(stall_cycles),      64'(e.stat));
         end
      end
   end

   initial begin
      for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
      m_uf   = 1'b0;
      m_stat = 0;
      reset  = 1'b1;
      flush  = 1'b0;
      sb_if.issue_valid   = 1'b0;
      sb_if.issue_rs1     = '0;
      sb_if.issue_use_rs1 = 1'b0;
      sb_if.issue_rs2     = '0;
      sb_if.issue_use_rs2 = 1'b0;
      sb_if.issue_rd      = '0;
      sb_if.issue_rd_we   = 1'b0;
      sb_if.wb_valid      = 1'b0;
      sb_if.wb_rd         = '0;

      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // RAW on r5: stall until writeback (or during it with bypass)
      cyc(0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
      cyc(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 5);
      cyc(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0);

      // r7 fills to max, fourth issue waits for one writeback
      repeat (3) cyc(0, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 7);
      cyc(0, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
      idle();
      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);

      // Same-cycle issue and writeback on r9
      cyc(0, 0, 1, 0, 0, 0, 0, 9, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 9, 1, 1, 9);
      idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);

      // Underflow on r12 survives a flush
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();

      // Flush drops pending r3/r4/r30 and beats a same-cycle issue
      cyc(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 30, 1, 0, 0);
      cyc(0, 0, 1, 3, 1, 30, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
      idle();

      // Register zero is never tracked
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0);
      cyc(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);

      repeat (3000) rand_cycle();

      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 3, 1, 4, 1, 5, 1, 0, 0);
      idle();

      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
